// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames a DATA_WIDTH-bit word as start bit, data
// LSB first, optional parity bit, then one or two stop bits. Bit timing is
// paced by the external one-cycle BAUD_TICK strobe.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   P_DATA     parallel word, valid while DATA_VALID=1
//   DATA_VALID word available, held until DATA_ACK
//   PAR_EN     1 = append parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   STOP2      0 = one stop bit, 1 = two stop bits
//   BAUD_TICK  one-cycle bit-period strobe
//   TX_OUT     registered serial line, idles high
//   Busy       registered, high while a frame is in progress
//   DATA_ACK   one-cycle pulse, word accepted
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  BAUD_TICK,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  DATA_ACK
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q,    state_d;
  logic                  tx_q,       tx_d;
  logic                  busy_q,     busy_d;
  logic                  ack_q,      ack_d;
  logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic                  par_en_q,   par_en_d;
  logic                  par_bit_q,  par_bit_d;
  logic                  stop2_q,    stop2_d;
  logic                  load;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    load       = 1'b0;

    if (BAUD_TICK) begin
      case (state_q)
        IDLE: begin
          load = DATA_VALID;
        end
        START: begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            // The shifter already holds the next bit at position 0.
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
        PARITY: begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        STOP: begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (DATA_VALID) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end

    // Shared accept path for IDLE and back-to-back frames out of STOP.
    if (load) begin
      state_d    = START;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
      ack_d      = 1'b1;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      shift_d    = P_DATA;
      par_en_d   = PAR_EN;
      par_bit_d  = (^P_DATA) ^ PAR_TYP;
      stop2_d    = STOP2;
    end
  end

  assign TX_OUT   = tx_q;
  assign Busy     = busy_q;
  assign DATA_ACK = ack_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic       BAUD_TICK;
  logic       TX_OUT;
  logic       Busy;
  logic       DATA_ACK;

  logic [4:0] P_DATA5;
  logic       DATA_VALID5;
  logic       TX_OUT5;
  logic       Busy5;
  logic       DATA_ACK5;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ack_total = 0;
  logic [7:0]  pending;
  logic        have_pending = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_engine #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .BAUD_TICK  (BAUD_TICK),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .DATA_ACK   (DATA_ACK)
  );

  uart_tx_engine #(.DATA_WIDTH(5)) dut5 (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA5),
    .DATA_VALID (DATA_VALID5),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .BAUD_TICK  (BAUD_TICK),
    .TX_OUT     (TX_OUT5),
    .Busy       (Busy5),
    .DATA_ACK   (DATA_ACK5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    if (DATA_ACK === 1'b1) ack_total++;
  endtask

  // Three quiet cycles, then one tick cycle; returns just after the tick edge.
  task automatic tick_period();
    BAUD_TICK = 1'b0;
    repeat (3) cyc();
    BAUD_TICK = 1'b1;
    cyc();
    BAUD_TICK = 1'b0;
  endtask

  // Character i of each string is the expected value right after tick i.
  task automatic run_ticks(input string tag, input string etx, input string ebusy,
                           input string eack, input bit toggle);
    int unsigned a0;
    int unsigned exp_acks;
    a0 = ack_total;
    exp_acks = 0;
    for (int i = 0; i < etx.len(); i++) begin
      tick_period();
      chk($sformatf("%s tx[%0d]", tag, i), 32'(TX_OUT), 32'(etx[i] == "1"));
      chk($sformatf("%s busy[%0d]", tag, i), 32'(Busy), 32'(ebusy[i] == "1"));
      chk($sformatf("%s ack[%0d]", tag, i), 32'(DATA_ACK), 32'(eack[i] == "1"));
      if (eack[i] == "1") exp_acks++;
      if (DATA_ACK === 1'b1) begin
        if (have_pending) begin
          P_DATA = pending;
          have_pending = 1'b0;
        end else begin
          DATA_VALID = 1'b0;
        end
      end
      if (toggle && i == 3) begin
        PAR_EN = ~PAR_EN;
        STOP2  = ~STOP2;
      end
    end
    chk($sformatf("%s ack_count", tag), ack_total - a0, exp_acks);
  endtask

  initial begin
    RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    STOP2 = 1'b0; BAUD_TICK = 1'b0; P_DATA5 = '0; DATA_VALID5 = 1'b0;
    cyc(); cyc();
    chk("reset tx", 32'(TX_OUT), 32'd1);
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset ack", 32'(DATA_ACK), 32'd0);
    chk("reset5 tx", 32'(TX_OUT5), 32'd1);
    RST = 1'b0;
    cyc();

    // 0xA5, even parity, one stop
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    run_ticks("a5_even", "010100101011", "111111111110", "100000000000", 1'b0);

    // 0xA5, odd parity
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0; DATA_VALID = 1'b1;
    run_ticks("a5_odd", "010100101111", "111111111110", "100000000000", 1'b0);

    // 0xA5, no parity, two stops
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1; DATA_VALID = 1'b1;
    run_ticks("a5_stop2", "010100101111", "111111111110", "100000000000", 1'b0);

    // back-to-back 0x3C then 0xFF
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    pending = 8'hFF; have_pending = 1'b1;
    run_ticks("b2b", "000111100101111111111", "111111111111111111110",
              "100000000010000000000", 1'b0);

    // DATA_VALID raised two cycles before a tick
    BAUD_TICK = 1'b0;
    cyc();
    P_DATA = 8'h0F; PAR_EN = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    cyc();
    chk("early ack0", 32'(DATA_ACK), 32'd0);
    chk("early tx0", 32'(TX_OUT), 32'd1);
    chk("early busy0", 32'(Busy), 32'd0);
    cyc();
    chk("early ack1", 32'(DATA_ACK), 32'd0);
    chk("early tx1", 32'(TX_OUT), 32'd1);
    BAUD_TICK = 1'b1;
    cyc();
    BAUD_TICK = 1'b0;
    chk("early accept ack", 32'(DATA_ACK), 32'd1);
    chk("early accept tx", 32'(TX_OUT), 32'd0);
    chk("early accept busy", 32'(Busy), 32'd1);
    DATA_VALID = 1'b0;
    run_ticks("early", "1111000011", "1111111110", "0000000000", 1'b0);

    // reset during data bit 3
    P_DATA = 8'h55; PAR_EN = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    run_ticks("rst_pre", "01010", "11111", "10000", 1'b0);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("rst tx", 32'(TX_OUT), 32'd1);
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst ack", 32'(DATA_ACK), 32'd0);
    run_ticks("rst_idle", "11", "00", "00", 1'b0);

    // reset and tick together with data pending: reset wins
    DATA_VALID = 1'b1; RST = 1'b1; BAUD_TICK = 1'b1;
    cyc();
    RST = 1'b0; BAUD_TICK = 1'b0;
    chk("rst_tick ack", 32'(DATA_ACK), 32'd0);
    chk("rst_tick tx", 32'(TX_OUT), 32'd1);
    chk("rst_tick busy", 32'(Busy), 32'd0);

    // fresh 0x55 frame, even parity
    P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    run_ticks("x55", "010101010011", "111111111110", "100000000000", 1'b0);

    // config toggled mid-frame keeps the latched format
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b1;
    run_ticks("toggle", "010100101011", "111111111110", "100000000000", 1'b1);

    // DATA_WIDTH=5 instance: 0x1F, even parity
    PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; DATA_VALID = 1'b0;
    P_DATA5 = 5'h1F; DATA_VALID5 = 1'b1;
    begin
      string etx5;
      string ebusy5;
      string eack5;
      etx5   = "011111111";
      ebusy5 = "111111110";
      eack5  = "100000000";
      for (int i = 0; i < etx5.len(); i++) begin
        tick_period();
        chk($sformatf("w5 tx[%0d]", i), 32'(TX_OUT5), 32'(etx5[i] == "1"));
        chk($sformatf("w5 busy[%0d]", i), 32'(Busy5), 32'(ebusy5[i] == "1"));
        chk($sformatf("w5 ack[%0d]", i), 32'(DATA_ACK5), 32'(eack5[i] == "1"));
        if (DATA_ACK5 === 1'b1) DATA_VALID5 = 1'b0;
      end
    end
    chk("w5 idle dut8 tx", 32'(TX_OUT), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine: FSM, serializer, parity generator and output mux in one block. Frames a DATA_WIDTH-bit word as start, data LSB first, optional parity, then 1 or 2 stop bits. Bit timing is paced by an external one-cycle BAUD_TICK strobe from the shared prescaler. It sits between the TX async FIFO read side and the TX pad.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.

Ports:
CLK         input   1           system clock; all logic on the rising edge
RST         input   1           synchronous, active-high reset
P_DATA      input   DATA_WIDTH  parallel word to send; valid while DATA_VALID=1
DATA_VALID  input   1           word available; held high until DATA_ACK
PAR_EN      input   1           1 = append parity bit
PAR_TYP     input   1           0 = even parity, 1 = odd parity
STOP2       input   1           0 = one stop bit, 1 = two stop bits
BAUD_TICK   input   1           one-cycle strobe; one bit period between consecutive ticks
TX_OUT      output  1           registered serial line; idles high
Busy        output  1           registered; high while a frame is in progress
DATA_ACK    output  1           one-cycle pulse; word accepted

Behaviour:
- Single clock. Reset is synchronous and active-high: RST=1 sampled at a CLK rising edge resets the block. It overrides all other inputs.
- Reset values: state=IDLE, TX_OUT=1, Busy=0, DATA_ACK=0, bit counter=0, stop counter=0.
- All outputs are registered. State and TX_OUT change only on cycles where BAUD_TICK=1.
- Accept rule: in IDLE, a cycle with DATA_VALID=1 and BAUD_TICK=1 is an accept.
  - DATA_ACK=1 in the following cycle only.
  - P_DATA, PAR_EN, PAR_TYP and STOP2 are latched into a shadow register on the accept.
  - Parity is computed from the latched data: even = XOR of data bits; odd = ~XOR.
  - State goes to START; TX_OUT=0 and Busy=1 from the next cycle.
- DATA_VALID without BAUD_TICK gives no accept. DATA_VALID is ignored outside the accept points.
- Changes to the config inputs mid-frame have no effect on the current frame.
- State machine: IDLE, START, DATA, PARITY, STOP. Every transition below happens on a BAUD_TICK.
  - START -> DATA: TX_OUT = data[0]; bit counter = 0.
  - DATA: on each tick, bit counter increments and TX_OUT = next bit.
  - DATA, at bit counter = DATA_WIDTH-1: go to PARITY (TX_OUT = parity) if latched PAR_EN=1; otherwise go to STOP (TX_OUT = 1).
  - PARITY -> STOP: TX_OUT = 1.
  - STOP, 1 stop bit: ends on the first tick in STOP.
  - STOP, 2 stop bits: ends on the second tick in STOP; the stop counter tracks this.
- End of STOP:
  - If DATA_VALID=1: treated as an accept. DATA_ACK is pulsed, new config and data are latched, and the state goes straight to START with no idle bit (back-to-back frames).
  - Otherwise: go to IDLE; TX_OUT=1 and Busy=0.
- Frame length = 1 + DATA_WIDTH + PAR_EN + (1 + STOP2) ticks, measured from the accept to Busy falling.
- Reset mid-frame: the next cycle forces TX_OUT=1, Busy=0 and IDLE. The partial frame is abandoned; no DATA_ACK is produced for it.
- RST and BAUD_TICK in the same cycle: reset wins.
- Bit counter width is clog2(DATA_WIDTH). It must never exceed DATA_WIDTH-1.

Test Plan:
- DATA_WIDTH=8, tick every 4 cycles, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_OUT per tick: 0, 1,0,1,0,0,1,0,1, 0, 1. DATA_ACK is one pulse. Busy is high for exactly 11 ticks.
- Same word with PAR_TYP=1 -> parity bit = 1. Same word with PAR_EN=0, STOP2=1 -> 0, data bits, 1, 1; Busy is high for 11 ticks.
- Two words 0x3C then 0xFF with DATA_VALID held, PAR_EN=0 -> the second start bit immediately follows the first stop bit. Busy never drops; two DATA_ACK pulses 10 ticks apart.
- DATA_VALID raised 2 cycles before a tick -> no DATA_ACK and TX_OUT=1 until the tick cycle. The accept happens on the tick.
- RST=1 during data bit 3 -> next cycle TX_OUT=1, Busy=0, IDLE. A new 0x55 frame afterwards is transmitted correctly.
- Toggle PAR_EN and STOP2 mid-frame -> the current frame keeps its latched format. DATA_WIDTH=5 build with 0x1F, even parity -> parity bit = 1.
